// File: rtl/arcade_input_conditioner_if.sv
// Host-side signal bundle for arcade_input_conditioner: PS/2 key word,
// merged joystick, video/cabinet status and the active-low IN0/IN1 words.
interface arcade_input_conditioner_if;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        vblank;
    logic        rotate;
    logic        cocktail;
    logic [7:0]  in0;
    logic [7:0]  in1;

    modport master (
        output ps2_key, joy, vblank, rotate, cocktail,
        input  in0, in1
    );

    modport slave (
        input  ps2_key, joy, vblank, rotate, cocktail,
        output in0, in1
    );
endinterface

// File: rtl/arcade_input_conditioner.sv
// arcade_input_conditioner: PS/2 key events + joystick -> pacman IN0/IN1.
// Tracks key state, rotates directions, stretches coins over vblank frames.
// Optional build macro FOURWAY_LOCK_EN: per-player four-way direction lock
// (only the most recently pressed direction passes).
module arcade_input_conditioner #(
    parameter int unsigned COIN_FRAMES = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    arcade_input_conditioner_if.slave bus
);
    localparam int unsigned NKEYS = 19;
    localparam int unsigned K_P1U = 0;
    localparam int unsigned K_P1D = 1;
    localparam int unsigned K_P1L = 2;
    localparam int unsigned K_P1R = 3;
    localparam int unsigned K_029 = 4;
    localparam int unsigned K_014 = 5;
    localparam int unsigned K_005 = 6;
    localparam int unsigned K_006 = 7;
    localparam int unsigned K_004 = 8;
    localparam int unsigned K_003 = 9;
    localparam int unsigned K_016 = 10;
    localparam int unsigned K_01E = 11;
    localparam int unsigned K_02E = 12;
    localparam int unsigned K_036 = 13;
    localparam int unsigned K_P2U = 14;
    localparam int unsigned K_P2D = 15;
    localparam int unsigned K_P2L = 16;
    localparam int unsigned K_P2R = 17;
    localparam int unsigned K_01C = 18;

    // Direction vectors are ordered {U,D,L,R}, matching joy[3:0].
    logic             tog_q;
    logic             event_c;
    logic [NKEYS-1:0] key_sel_c;
    logic [NKEYS-1:0] keys_q, keys_d;
    logic [3:0]       p1_raw_c, p2_raw_c, p1_dir_c, p2_dir_c;
    logic [3:0]       p1_s1_q, p1_s2_q, p2_s1_q, p2_s2_q;
    logic [3:0]       p1_out_c, p2_out_c;
    logic [3:0]       btn_c, btn_q;    // {cocktail, start2, start1, cheat}
    logic             vblank_q, vb_rise_c;
    logic [1:0]       coin_src_c, coin_src_q, coin_rise_c;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [7:0]       in0_q, in0_d, in1_q, in1_d;
    logic             unused_joy_c;

    assign unused_joy_c = ^bus.joy[15:8];

    function automatic logic [3:0] rot_dir(input logic [3:0] d, input logic r);
        // Rotated screen: U<-L, D<-R, L<-D, R<-U
        return r ? {d[1], d[0], d[2], d[3]} : d;
    endfunction

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic rise, input logic vb);
        logic [CNT_W-1:0] n;
        n = cnt;
        if (rise && (cnt == '0)) begin
            n = CNT_W'(COIN_FRAMES);
        end else if (vb && (cnt != '0)) begin
            n = cnt - CNT_W'(1);
        end
        return n;
    endfunction

    // Scan-code decode and key-state update on a toggle change
    always_comb begin
        key_sel_c = '0;
        case (bus.ps2_key[8:0])
            9'h075, 9'h175: key_sel_c[K_P1U] = 1'b1;
            9'h072, 9'h172: key_sel_c[K_P1D] = 1'b1;
            9'h06B, 9'h16B: key_sel_c[K_P1L] = 1'b1;
            9'h074, 9'h174: key_sel_c[K_P1R] = 1'b1;
            9'h029:         key_sel_c[K_029] = 1'b1;
            9'h014:         key_sel_c[K_014] = 1'b1;
            9'h005:         key_sel_c[K_005] = 1'b1;
            9'h006:         key_sel_c[K_006] = 1'b1;
            9'h004:         key_sel_c[K_004] = 1'b1;
            9'h003:         key_sel_c[K_003] = 1'b1;
            9'h016:         key_sel_c[K_016] = 1'b1;
            9'h01E:         key_sel_c[K_01E] = 1'b1;
            9'h02E:         key_sel_c[K_02E] = 1'b1;
            9'h036:         key_sel_c[K_036] = 1'b1;
            9'h02D:         key_sel_c[K_P2U] = 1'b1;
            9'h02B:         key_sel_c[K_P2D] = 1'b1;
            9'h023:         key_sel_c[K_P2L] = 1'b1;
            9'h034:         key_sel_c[K_P2R] = 1'b1;
            9'h01C:         key_sel_c[K_01C] = 1'b1;
            default:        key_sel_c = '0;
        endcase
        event_c = bus.ps2_key[10] ^ tog_q;
        keys_d  = keys_q;
        if (event_c) begin
            keys_d = (keys_q & ~key_sel_c) | (key_sel_c & {NKEYS{bus.ps2_key[9]}});
        end
    end

    // Merge keys with joystick, rotate directions, collect buttons and coin sources
    always_comb begin
        p1_raw_c = {keys_q[K_P1U], keys_q[K_P1D], keys_q[K_P1L], keys_q[K_P1R]} | bus.joy[3:0];
        p2_raw_c = {keys_q[K_P2U], keys_q[K_P2D], keys_q[K_P2L], keys_q[K_P2R]} | bus.joy[3:0];
        p1_dir_c = rot_dir(p1_raw_c, bus.rotate);
        p2_dir_c = rot_dir(p2_raw_c, bus.rotate);
        btn_c    = {bus.cocktail,
                    keys_q[K_006] | keys_q[K_01E] | bus.joy[6],
                    keys_q[K_005] | keys_q[K_016] | bus.joy[5],
                    keys_q[K_029] | keys_q[K_014] | keys_q[K_01C] | keys_q[K_003] | bus.joy[4]};
        coin_src_c  = {keys_q[K_036], keys_q[K_02E] | keys_q[K_004] | bus.joy[7]};
        coin_rise_c = coin_src_c & ~coin_src_q;
        vb_rise_c   = bus.vblank & ~vblank_q;
        cnt1_d      = next_cnt(cnt1_q, coin_rise_c[0], vb_rise_c);
        cnt2_d      = next_cnt(cnt2_q, coin_rise_c[1], vb_rise_c);
    end

`ifdef FOURWAY_LOCK_EN
    logic [3:0] p1_mask_q, p1_mask_d, p2_mask_q, p2_mask_d;

    function automatic logic [3:0] pick_one(input logic [3:0] n);
        // Priority U > D > L > R when several directions rise together
        if (n[3])      return 4'b1000;
        else if (n[2]) return 4'b0100;
        else if (n[1]) return 4'b0010;
        else           return 4'b0001;
    endfunction

    // Reload each player's lock mask on any freshly pressed direction
    always_comb begin
        p1_mask_d = p1_mask_q;
        p2_mask_d = p2_mask_q;
        if ((p1_s1_q & ~p1_s2_q) != 4'b0000) p1_mask_d = pick_one(p1_s1_q & ~p1_s2_q);
        if ((p2_s1_q & ~p2_s2_q) != 4'b0000) p2_mask_d = pick_one(p2_s1_q & ~p2_s2_q);
        p1_out_c = p1_s2_q & p1_mask_q;
        p2_out_c = p2_s2_q & p2_mask_q;
    end

    // Lock mask registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_mask_q <= '0;
            p2_mask_q <= '0;
        end else begin
            p1_mask_q <= p1_mask_d;
            p2_mask_q <= p2_mask_d;
        end
    end
`else
    assign p1_out_c = p1_s2_q;
    assign p2_out_c = p2_s2_q;
`endif

    // Active-low output words
    always_comb begin
        in0_d = ~{1'b0, (cnt2_q != '0), (cnt1_q != '0), btn_q[0],
                  p1_out_c[2], p1_out_c[0], p1_out_c[1], p1_out_c[3]};
        in1_d = ~{btn_q[3], btn_q[2], btn_q[1], 1'b0,
                  p2_out_c[2], p2_out_c[0], p2_out_c[1], p2_out_c[3]};
    end

    // State, pipeline, coin counter and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q      <= 1'b0;
            keys_q     <= '0;
            p1_s1_q    <= '0;
            p1_s2_q    <= '0;
            p2_s1_q    <= '0;
            p2_s2_q    <= '0;
            btn_q      <= '0;
            vblank_q   <= 1'b0;
            coin_src_q <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            in0_q      <= 8'hFF;
            in1_q      <= 8'hFF;
        end else begin
            tog_q      <= bus.ps2_key[10];
            keys_q     <= keys_d;
            p1_s1_q    <= p1_dir_c;
            p1_s2_q    <= p1_s1_q;
            p2_s1_q    <= p2_dir_c;
            p2_s2_q    <= p2_s1_q;
            btn_q      <= btn_c;
            vblank_q   <= bus.vblank;
            coin_src_q <= coin_src_c;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
        end
    end

    assign bus.in0 = in0_q;
    assign bus.in1 = in1_q;
endmodule
